// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: stage enables, flush/bubble, EX forwarding selects, memory-wait and halt-drain FSM.
// Optional performance counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_controller #(
  parameter int HALT_DRAIN_CYCLES = 3,
  parameter int CNT_W             = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_src1,
  input  logic [4:0] id_src2,
  input  logic [4:0] idex_dest,
  input  logic       idex_regwrite,
  input  logic       idex_memtoreg,
  input  logic [4:0] idex_src1,
  input  logic [4:0] idex_src2,
  input  logic [4:0] exmem_dest,
  input  logic       exmem_regwrite,
  input  logic [4:0] memwb_dest,
  input  logic       memwb_regwrite,
  input  logic       ex_redirect,
  input  logic       mem_req,
  input  logic       mem_ready,
  input  logic       id_halted,
  output logic       pc_we,
  output logic       ifid_we,
  output logic       idex_we,
  output logic       exmem_we,
  output logic       memwb_we,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       halt_done
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] mem_wait_cycles
`endif
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;

  state_t     state_reg, state_next, ret_reg, ret_next, eff_state;
  logic [3:0] cnt_reg, cnt_next;
  logic       freeze_req, load_use;
  logic       frozen_evt, redirect_evt, load_use_evt;

  assign freeze_req = mem_req & ~mem_ready;
  assign load_use   = idex_memtoreg & idex_regwrite & (idex_dest != 5'd0) &
                      ((id_src1 != 5'd0 && id_src1 == idex_dest) ||
                       (id_src2 != 5'd0 && id_src2 == idex_dest));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
      ret_reg   <= RUN;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      ret_reg   <= ret_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    idex_we      = 1'b1;
    exmem_we     = 1'b1;
    memwb_we     = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    halt_done    = 1'b0;
    frozen_evt   = 1'b0;
    redirect_evt = 1'b0;
    load_use_evt = 1'b0;
    ret_next     = ret_reg;
    cnt_next     = cnt_reg;
    // A released memory wait behaves exactly like the state it interrupted.
    eff_state    = (state_reg == MEM_WAIT && mem_ready) ? ret_reg : state_reg;
    state_next   = eff_state;
    if (rst) begin
      {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_next  = RUN;
      ret_next    = RUN;
      cnt_next    = 4'd0;
    end else begin
      case (eff_state)
        RUN: begin
          if (freeze_req) begin
            {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b0;
            frozen_evt = 1'b1;
            state_next = MEM_WAIT;
            ret_next   = RUN;
          end else if (ex_redirect) begin
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            redirect_evt = 1'b1;
          end else if (load_use) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_bubble  = 1'b1;
            load_use_evt = 1'b1;
          end else if (id_halted) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            state_next = DRAIN;
            cnt_next   = 4'd0;
          end
        end
        DRAIN: begin
          if (freeze_req) begin
            {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b0;
            frozen_evt = 1'b1;
            state_next = MEM_WAIT;
            ret_next   = DRAIN;
          end else begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
            if (cnt_reg == 4'(HALT_DRAIN_CYCLES - 1)) state_next = HALTED;
            else cnt_next = cnt_reg + 4'd1;
          end
        end
        MEM_WAIT: begin
          {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b0;
          frozen_evt = 1'b1;
        end
        default: begin
          {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b0;
          halt_done = 1'b1;
        end
      endcase
    end
  end

  // EX/MEM result is younger than MEM/WB, so it takes priority.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!rst) begin
      if (exmem_regwrite && exmem_dest != 5'd0 && exmem_dest == idex_src1)      fwd_a = 2'b10;
      else if (memwb_regwrite && memwb_dest != 5'd0 && memwb_dest == idex_src1) fwd_a = 2'b01;
      if (exmem_regwrite && exmem_dest != 5'd0 && exmem_dest == idex_src2)      fwd_b = 2'b10;
      else if (memwb_regwrite && memwb_dest != 5'd0 && memwb_dest == idex_src2) fwd_b = 2'b01;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic stall_evt, mem_wait_evt;
  assign stall_evt    = frozen_evt | load_use_evt;
  assign mem_wait_evt = (state_reg == MEM_WAIT) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles    <= '0;
      flush_count     <= '0;
      mem_wait_cycles <= '0;
    end else if (state_reg != HALTED) begin
      if (stall_evt && stall_cycles != '1)       stall_cycles    <= stall_cycles + 1'b1;
      if (redirect_evt && flush_count != '1)     flush_count     <= flush_count + 1'b1;
      if (mem_wait_evt && mem_wait_cycles != '1) mem_wait_cycles <= mem_wait_cycles + 1'b1;
    end
  end
`endif

endmodule
